// File: rtl/fp_cvt_arbiter.sv
// fp_cvt_arbiter: shares one combinational int32 -> float32 converter between two requesters.
//   Requester 0 is the integer pipeline (fcvt.s.w), requester 1 the memory-mapped accelerator port.
//   Round-robin arbitration feeds a 2-stage registered pipeline: S1 holds the operand, the
//   converter sits between S1 and S2, and S2 drives the result outputs directly.
//
// Parameters:
//   TAG_W     - width of request/response tag
//   RESET_PTR - requester that holds priority first after reset (0 or 1)
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   reqK_valid/ready          - request handshake for requester K (K = 0, 1)
//   reqK_data, reqK_tag       - signed int32 operand and tag for requester K
//   res_valid/ready           - result handshake
//   res_data, res_src, res_tag- float32 result, issuing requester, echoed tag
//
// Optional build macro FP_CVT_ARB_STATS_EN adds:
//   cnt0, cnt1    - 32-bit accepted-request counters per requester (wrapping)
//   conflict_cnt  - 16-bit count of cycles with both requesters valid while S1 can accept
module fp_cvt_arbiter #(
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned RESET_PTR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
`ifdef FP_CVT_ARB_STATS_EN
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1,
  output logic [15:0]      conflict_cnt,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  // int32 -> float32, round-to-nearest-even. The magnitude is normalised so its leading one
  // sits at bit 31; bits [30:8] are the mantissa and bits [7:0] are what rounding discards.
  // A rounding carry out of the mantissa ripples into the exponent, which is exactly the
  // renormalisation step.
  function automatic logic [31:0] int_to_f32(input logic [31:0] x);
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  msb;
    logic [31:0] norm;
    logic [22:0] mant;
    logic [7:0]  expo;
    logic        guard;
    logic        sticky;
    logic        rnd;
    sign = x[31];
    mag  = sign ? (~x + 32'd1) : x;  // 0x80000000 maps to itself, read as unsigned 2^31
    msb  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm   = mag << (5'd31 - msb);
    mant   = norm[30:8];
    guard  = norm[7];
    sticky = |norm[6:0];
    rnd    = guard & (sticky | mant[0]);
    expo   = 8'd127 + {3'd0, msb};
    if (mag == 32'd0) begin
      int_to_f32 = 32'd0;
    end else begin
      int_to_f32 = {sign, expo, mant} + {31'd0, rnd};
    end
  endfunction

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic             s1_src_q, s1_src_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_src_q, res_src_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  // Round-robin pointer: requester that wins when both are valid
  logic             ptr_q, ptr_d;

  logic             s2_free;
  logic             s1_adv;
  logic             s1_free;
  logic             grant0;
  logic             grant1;
  logic [31:0]      cvt_out;

  assign s2_free = !res_valid_q || res_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign s1_free = !s1_valid_q || s1_adv;

  // A lone valid requester always wins; a tie goes to the pointer holder.
  assign grant0 = s1_free && req0_valid && (!req1_valid || (ptr_q == 1'b0));
  assign grant1 = s1_free && req1_valid && (!req0_valid || (ptr_q == 1'b1));

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign cvt_out = int_to_f32(s1_data_q);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_src_d    = s1_src_q;
    s1_tag_d    = s1_tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_src_d   = res_src_q;
    res_tag_d   = res_tag_q;
    ptr_d       = ptr_q;

    // S1: refill whenever it empties or advances; keep old operand bits if nothing is granted
    if (s1_free) begin
      s1_valid_d = grant0 || grant1;
      if (grant1) begin
        s1_data_d = req1_data;
        s1_src_d  = 1'b1;
        s1_tag_d  = req1_tag;
      end else if (grant0) begin
        s1_data_d = req0_data;
        s1_src_d  = 1'b0;
        s1_tag_d  = req0_tag;
      end
    end

    // S2: load the converted result, or empty out once the consumer has taken it
    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_data_d  = cvt_out;
      res_src_d   = s1_src_q;
      res_tag_d   = s1_tag_q;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end

    // Priority passes to the requester that was not just served
    if (grant0) begin
      ptr_d = 1'b1;
    end else if (grant1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= 32'd0;
      s1_src_q    <= 1'b0;
      s1_tag_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      res_src_q   <= 1'b0;
      res_tag_q   <= '0;
      ptr_q       <= 1'(RESET_PTR);
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_src_q    <= s1_src_d;
      s1_tag_q    <= s1_tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_src_q   <= res_src_d;
      res_tag_q   <= res_tag_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_src   = res_src_q;
  assign res_tag   = res_tag_q;

`ifdef FP_CVT_ARB_STATS_EN
  logic [31:0] cnt0_q;
  logic [31:0] cnt1_q;
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q         <= 32'd0;
      cnt1_q         <= 32'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      if (grant0) cnt0_q <= cnt0_q + 32'd1;
      if (grant1) cnt1_q <= cnt1_q + 32'd1;
      if (req0_valid && req1_valid && s1_free) conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign cnt0         = cnt0_q;
  assign cnt1         = cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
